// File: rtl/key_filter.sv
// key_filter: debounces one active-low push-button into clean key events.
// A two-flop synchronizer feeds a one-cycle edge detector, and a 4-state FSM
// accepts an edge only after the synchronized level has stayed stable for
// CNT_MAX cycles. Each accepted press or release produces a one-cycle
// key_flag pulse, and the debounced key_state level updates on that same cycle.
//
// Key-event interface contract (producer side): key_flag is a registered,
// single-cycle strobe with no back-pressure; consumers must act on it in the
// cycle it is high. key_state is valid in that cycle, so a press is
// key_flag & ~key_state and a release is key_flag & key_state.
module key_filter #(
    parameter int CNT_MAX = 1_000_000,
    parameter int CNT_W   = 20
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_in,
    output logic       key_flag,
    output logic       key_state,
    // FSM state for observation: 0 IDLE, 1 FILTER0, 2 DOWN, 3 FILTER1
    output logic [1:0] dbg_state
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,  // released, waiting for a falling edge
        FILTER0 = 2'd1,  // falling edge seen, qualifying a press
        DOWN    = 2'd2,  // pressed, waiting for a rising edge
        FILTER1 = 2'd3   // rising edge seen, qualifying a release
    } state_t;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CNT_MAX - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             r_sync1;
    logic             r_key_s;
    logic             r_key_d;
    logic             w_nedge;
    logic             w_pedge;
    logic             w_cnt_done;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic             r_key_flag;
    logic             w_key_flag_nxt;
    logic             r_key_state;
    logic             w_key_state_nxt;

    // Synchronize the raw pin and keep one cycle of history for edge detection.
    // All three reset to 1 (released) so that a key already held during reset
    // shows up as a fresh falling edge once reset lifts.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= 1'b1;
            r_key_s <= 1'b1;
            r_key_d <= 1'b1;
        end else begin
            r_sync1 <= key_in;
            r_key_s <= r_sync1;
            r_key_d <= r_key_s;
        end
    end

    assign w_nedge    = r_key_d & ~r_key_s;
    assign w_pedge    = ~r_key_d & r_key_s;
    assign w_cnt_done = (r_cnt == CNT_LAST);

    // State, counter and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_cnt       <= '0;
            r_key_flag  <= 1'b0;
            r_key_state <= 1'b1;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_key_flag  <= w_key_flag_nxt;
            r_key_state <= w_key_state_nxt;
        end
    end

    // Next-state logic. An opposing edge always wins over the counter reaching
    // its last value, so a bounce landing on the final cycle cancels the event.
    // The counter is forced to 0 outside the filter states and never wraps,
    // because reaching CNT_LAST always leaves the filter state.
    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = r_cnt;
        w_key_flag_nxt  = 1'b0;
        w_key_state_nxt = r_key_state;
        case (r_state)
            IDLE: begin
                w_cnt_nxt = '0;
                if (w_nedge) begin
                    w_state_nxt = FILTER0;
                end
            end
            FILTER0: begin
                if (w_pedge) begin
                    w_state_nxt = IDLE;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt     = DOWN;
                    w_cnt_nxt       = '0;
                    w_key_flag_nxt  = 1'b1;
                    w_key_state_nxt = 1'b0;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            DOWN: begin
                w_cnt_nxt = '0;
                if (w_pedge) begin
                    w_state_nxt = FILTER1;
                end
            end
            FILTER1: begin
                if (w_nedge) begin
                    w_state_nxt = DOWN;
                    w_cnt_nxt   = '0;
                end else if (w_cnt_done) begin
                    w_state_nxt     = IDLE;
                    w_cnt_nxt       = '0;
                    w_key_flag_nxt  = 1'b1;
                    w_key_state_nxt = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_ONE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    assign key_flag  = r_key_flag;
    assign key_state = r_key_state;
    assign dbg_state = r_state;

endmodule

// File: tb/tb_key_filter.sv
// tb_key_filter: directed scenarios followed by randomized key_in activity,
// compared every cycle against a run-length reference model of the debouncer.
module tb_key_filter;

    localparam int CNT_MAX = 4;
    localparam int CNT_W   = 3;
    localparam logic [1:0] ST_IDLE = 2'd0;

    logic       clk    = 1'b0;
    logic       rst_n  = 1'b0;
    logic       key_in = 1'b1;
    logic       key_flag;
    logic       key_state;
    logic [1:0] dbg_state;

    int n_checks = 0;
    int n_pass   = 0;

    key_filter #(
        .CNT_MAX(CNT_MAX),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .key_in   (key_in),
        .key_flag (key_flag),
        .key_state(key_state),
        .dbg_state(dbg_state)
    );

    // Clock: 20 ns period.
    always #10 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    endtask

    // Reference model. The debounced level flips when the synchronized key
    // value has been the same for CNT_MAX+1 consecutive samples (the first
    // differing sample is the edge, then CNT_MAX stable cycles) and differs
    // from the current level. The flag is asserted for the cycle after that.
    logic m_s1      = 1'b1;
    logic m_s2      = 1'b1;
    logic run_val   = 1'b1;
    int   run_len   = CNT_MAX + 1;
    logic exp_flag  = 1'b0;
    logic exp_level = 1'b1;

    task automatic model_step();
        if (!rst_n) begin
            m_s1      = 1'b1;
            m_s2      = 1'b1;
            run_val   = 1'b1;
            run_len   = CNT_MAX + 1;
            exp_flag  = 1'b0;
            exp_level = 1'b1;
        end else begin
            exp_flag = 1'b0;
            if (m_s2 == run_val) begin
                if (run_len <= CNT_MAX) run_len++;
            end else begin
                run_val = m_s2;
                run_len = 1;
            end
            if (run_len == CNT_MAX + 1 && run_val != exp_level) begin
                exp_flag  = 1'b1;
                exp_level = run_val;
            end
            m_s2 = m_s1;
            m_s1 = key_in;
        end
    endtask

    always @(posedge clk or negedge rst_n) model_step();

    // Scoreboard: compare every cycle on the falling edge.
    logic prev_flag = 1'b0;
    int   pulse_cnt = 0;

    task automatic score_cycle();
        check_eq("key_flag", 32'(key_flag), 32'(exp_flag));
        check_eq("key_state", 32'(key_state), 32'(exp_level));
        check_eq("flag_back_to_back", 32'(key_flag & prev_flag), 32'd0);
        if (key_flag) pulse_cnt++;
        prev_flag = key_flag;
    endtask

    always @(negedge clk) score_cycle();

    // Drivers: inputs change 2 ns after the falling edge.
    task automatic hold(input logic v, input int n);
        key_in = v;
        repeat (n) @(negedge clk);
        #2;
    endtask

    // Drive v, watch n cycles, return first cycle index with key_flag and pulse count.
    task automatic edge_and_watch(input logic v, input int n, output int first_idx, output int pulses);
        first_idx = -1;
        pulses    = 0;
        key_in    = v;
        for (int i = 1; i <= n; i++) begin
            @(negedge clk);
            if (key_flag) begin
                pulses++;
                if (first_idx < 0) first_idx = i;
            end
        end
        #2;
    endtask

    task automatic pulse_reset(input int n);
        rst_n = 1'b0;
        repeat (n) @(negedge clk);
        #2;
        rst_n = 1'b1;
    endtask

    int idx;
    int pulses;
    int base;

    initial begin
        // Reset held 60 ns with key released.
        repeat (3) @(negedge clk);
        check_eq("reset_flag", 32'(key_flag), 32'd0);
        check_eq("reset_state", 32'(key_state), 32'd1);
        check_eq("reset_fsm", 32'(dbg_state), 32'(ST_IDLE));
        #2;
        rst_n = 1'b1;
        hold(1'b1, 4);

        // Bounce on press: nothing accepted.
        base = pulse_cnt;
        hold(1'b0, 2);
        hold(1'b1, 1);
        hold(1'b0, 2);
        hold(1'b1, 10);
        check_eq("bounce_pulses", 32'(pulse_cnt - base), 32'd0);
        check_eq("bounce_state", 32'(key_state), 32'd1);
        check_eq("bounce_fsm", 32'(dbg_state), 32'(ST_IDLE));

        // Clean press, then clean release.
        base = pulse_cnt;
        edge_and_watch(1'b0, 10, idx, pulses);
        check_eq("press_latency", 32'(idx), 32'd7);
        check_eq("press_pulses", 32'(pulses), 32'd1);
        check_eq("press_state", 32'(key_state), 32'd0);
        edge_and_watch(1'b1, 10, idx, pulses);
        check_eq("release_latency", 32'(idx), 32'd7);
        check_eq("release_pulses", 32'(pulses), 32'd1);
        check_eq("release_state", 32'(key_state), 32'd1);
        check_eq("press_release_total", 32'(pulse_cnt - base), 32'd2);

        // Reset mid-filter with the key still held down.
        hold(1'b0, 2);
        rst_n = 1'b0;
        #1;
        check_eq("midreset_flag", 32'(key_flag), 32'd0);
        check_eq("midreset_state", 32'(key_state), 32'd1);
        check_eq("midreset_fsm", 32'(dbg_state), 32'(ST_IDLE));
        @(negedge clk);
        #2;
        rst_n = 1'b1;
        edge_and_watch(1'b0, 10, idx, pulses);
        check_eq("post_reset_press_latency", 32'(idx), 32'd7);
        check_eq("post_reset_press_pulses", 32'(pulses), 32'd1);
        check_eq("post_reset_state", 32'(key_state), 32'd0);
        hold(1'b1, 10);

        // Edge collision: low exactly CNT_MAX cycles is cancelled.
        base = pulse_cnt;
        hold(1'b0, CNT_MAX);
        hold(1'b1, 10);
        check_eq("collision_pulses", 32'(pulse_cnt - base), 32'd0);
        check_eq("collision_state", 32'(key_state), 32'd1);
        check_eq("collision_fsm", 32'(dbg_state), 32'(ST_IDLE));

        // One cycle longer is just enough to be accepted.
        base = pulse_cnt;
        hold(1'b0, CNT_MAX + 1);
        hold(1'b0, 6);
        check_eq("min_press_pulses", 32'(pulse_cnt - base), 32'd1);
        check_eq("min_press_state", 32'(key_state), 32'd0);
        hold(1'b1, 10);

        // Randomized activity with occasional resets.
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 39) == 0) pulse_reset($urandom_range(1, 2));
            else hold(1'($urandom_range(0, 1)), $urandom_range(1, 9));
        end
        hold(1'b1, 12);
        check_eq("final_state", 32'(key_state), 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
